// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs operand fields and a signed immediate into an
// instruction word behind a 2-entry output buffer. Build option: SHAMT_CHECK_EN.
module instr_encoder #(
  parameter int ADDR_W   = 32,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_fmt,
  input  logic [6:0]          in_opcode,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic [2:0]          in_funct3,
  input  logic [6:0]          in_funct7,
  input  logic [31:0]         in_imm,
  input  logic                addr_load,
  input  logic [ADDR_W-1:0]   addr_load_val,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } entry_t;

  entry_t              buf_q [2];
  logic                rd_ptr_q, wr_ptr_q;
  logic [1:0]          count_q, count_d;
  logic                in_ready_q;
  logic [ADDR_W-1:0]   addr_q, addr_d, word_addr;
  logic [ERRCNT_W-1:0] err_cnt_q;

  logic        push, pop;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic        fits_12, fits_13, fits_21;

  // A value fits an N-bit signed field when all bits from N-1 upward agree.
  assign fits_12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits_13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits_21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    enc_instr = 32'h0000_0013;
    enc_err   = 1'b1;
    case (in_fmt)
      FMT_R: begin
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = 1'b0;
      end
      FMT_I: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = ~fits_12;
      end
      FMT_S: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err   = ~fits_12;
      end
      FMT_B: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_err   = ~fits_13 | in_imm[0];
      end
      FMT_U: begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
        enc_err   = |in_imm[11:0];
      end
      FMT_J: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err   = ~fits_21 | in_imm[0];
      end
      default: ;
    endcase
`ifdef SHAMT_CHECK_EN
    // OP-IMM shifts: upper immediate bits select SLLI/SRLI/SRAI, rest must be zero.
    if (in_fmt == FMT_I && in_opcode == 7'b0010011) begin
      if (in_funct3 == 3'b001 && in_imm[11:5] != 7'b0000000)
        enc_err = 1'b1;
      if (in_funct3 == 3'b101 && in_imm[11:5] != 7'b0000000 && in_imm[11:5] != 7'b0100000)
        enc_err = 1'b1;
    end
`endif
  end

  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;
  assign word_addr = addr_load ? addr_load_val : addr_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 2'd1;
    else if (!push && pop)
      count_d = count_q - 2'd1;
  end

  always_comb begin
    addr_d = addr_q;
    if (push)
      addr_d = word_addr + ADDR_W'(4);
    else if (addr_load)
      addr_d = addr_load_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++)
        buf_q[i] <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
      addr_q     <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= '{instr: enc_instr, addr: word_addr, err: enc_err};
        wr_ptr_q        <= ~wr_ptr_q;
        if (enc_err && err_cnt_q != {ERRCNT_W{1'b1}})
          err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
      end
      if (pop)
        rd_ptr_q <= ~rd_ptr_q;
      count_q    <= count_d;
      in_ready_q <= (count_d != 2'd2);
      addr_q     <= addr_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_instr = buf_q[rd_ptr_q].instr;
  assign out_addr  = buf_q[rd_ptr_q].addr;
  assign out_err   = buf_q[rd_ptr_q].err;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written
// backpressure/reset sequences, and randomized traffic against a reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        addr_load;
  logic [31:0] addr_load_val;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;

`ifdef SHAMT_CHECK_EN
  localparam bit SHAMT = 1'b1;
`else
  localparam bit SHAMT = 1'b0;
`endif

  instr_encoder #(.ADDR_W(32), .ERRCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .addr_load(addr_load), .addr_load_val(addr_load_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: immediate bit slices taken arithmetically, ranges as signed integers.
  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    longint unsigned m;
    m = (64'd1 << (hi - lo + 1)) - 64'd1;
    return 32'((longint'(v) >> lo) & m);
  endfunction

  function automatic void model_encode(
    input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
    output logic [31:0] ins, output bit er);
    longint v;
    logic [31:0] base;
    v    = longint'($signed(imm));
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    ins  = 32'h0000_0013;
    er   = 1'b1;
    case (f)
      3'd0: begin
        ins = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
        er  = 1'b0;
      end
      3'd1: begin
        ins = (fld(imm, 11, 0) << 20) | base | (32'(rd) << 7);
        er  = (v < -2048) || (v > 2047);
        if (SHAMT && op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          if (!(fld(imm, 11, 5) == 0 || (f3 == 3'd5 && fld(imm, 11, 5) == 32)))
            er = 1'b1;
        end
      end
      3'd2: begin
        ins = (fld(imm, 11, 5) << 25) | (32'(rs2) << 20) | base | (fld(imm, 4, 0) << 7);
        er  = (v < -2048) || (v > 2047);
      end
      3'd3: begin
        ins = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (32'(rs2) << 20) | base |
              (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7);
        er  = (v < -4096) || (v > 4094) || (v % 2 != 0);
      end
      3'd4: begin
        ins = (imm / 4096) * 4096 | (32'(rd) << 7) | 32'(op);
        er  = (imm % 4096) != 0;
      end
      3'd5: begin
        ins = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20) |
              (fld(imm, 19, 12) << 12) | (32'(rd) << 7) | 32'(op);
        er  = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
      end
      default: ;
    endcase
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    bit          err;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] m_addr;
  int          m_errcnt;
  bit          mon_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] ins, a;
    bit          er;
    if (!rst_n) begin
      mq.delete();
      m_addr   = 0;
      m_errcnt = 0;
    end else if (in_valid && in_ready) begin
      model_encode(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, ins, er);
      a = addr_load ? addr_load_val : m_addr;
      mq.push_back('{instr: ins, addr: a, err: er});
      m_addr = a + 32'd4;
      if (er && m_errcnt < 255) m_errcnt++;
    end else if (addr_load) begin
      m_addr = addr_load_val;
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("mon_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("mon_in_ready", 32'(in_ready), 32'(mq.size() < 2));
      chk("mon_err_cnt", 32'(err_cnt), 32'(m_errcnt));
      if (out_valid && mq.size() != 0) begin
        chk("mon_instr", out_instr, mq[0].instr);
        chk("mon_addr", out_addr, mq[0].addr);
        chk("mon_err", 32'(out_err), 32'(mq[0].err));
        if (out_ready) void'(mq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input bit ld, input logic [31:0] ldv);
    int n = 0;
    drive(f, op, rd, rs1, rs2, f3, f7, imm);
    addr_load = ld; addr_load_val = ldv; in_valid = 1'b1;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    tick();
    in_valid = 1'b0; addr_load = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    bit          exp_err;
  } vec_t;

  vec_t tbl[18];

  initial begin : main
    int n_err_tbl;
    logic [31:0] got[$];
    bit c_acc;
    int bnd[18];

    tbl[0]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        32'h0050_0093, 1'b0};
    tbl[1]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,        32'h0020_A423, 1'b0};
    tbl[2]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
    tbl[3]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     32'h8000_0093, 1'b1};
    tbl[4]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd6,        32'h0000_0363, 1'b0};
    tbl[5]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,        32'h0000_0163, 1'b1};
    tbl[6]  = '{3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4031_00B3, 1'b0};
    tbl[7]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    tbl[8]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 32'h1234_52B7, 1'b1};
    tbl[9]  = '{3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0,        32'h0000_0013, 1'b1};
    tbl[10] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 1'b0};
    tbl[11] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,     32'h7E00_0FE3, 1'b0};
    tbl[12] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,     32'h8000_0063, 1'b1};
    tbl[13] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF0_0000, 32'h8000_006F, 1'b0};
    tbl[14] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, 32'h8000_006F, 1'b1};
    tbl[15] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd5, 7'h00, 32'h0000_0405, 32'h4050_5093, 1'b0};
    tbl[16] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd5, 7'h00, 32'h0000_0205, 32'h2050_5093, SHAMT};
    tbl[17] = '{3'd2, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F7FF, 32'h7E00_0FA3, 1'b1};

    bnd = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
            -1048577, -1048576, 1048574, 1048575, 1048576, 0, 1, -1, 32'h1234_5000};

    rst_n = 1'b0; in_valid = 1'b0; addr_load = 1'b0; addr_load_val = '0; out_ready = 1'b1;
    drive(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'd0);
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    mon_en = 1'b1;

    n_err_tbl = 0;
    foreach (tbl[i]) begin
      send(tbl[i].fmt, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].f3,
           tbl[i].f7, tbl[i].imm, 1'b0, 32'd0);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("tbl%0d_instr", i), out_instr, tbl[i].exp_instr);
      chk($sformatf("tbl%0d_err", i), 32'(out_err), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_addr", i), out_addr, 32'(i * 4));
      if (tbl[i].exp_err) n_err_tbl++;
    end
    tick();
    chk("tbl_err_cnt", 32'(err_cnt), 32'(n_err_tbl));

    // addr_load coinciding with an accept, then plain increment from the loaded value
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h800, 1'b1, 32'h800);
    chk("ld_instr", out_instr, 32'h0010_00EF);
    chk("ld_addr", out_addr, 32'h800);
    send(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'd0, 1'b0, 32'd0);
    chk("ld_next_addr", out_addr, 32'h804);
    tick();

    // backpressure: two words fill the buffer, third waits until a slot frees
    out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd1, 1'b0, 32'd0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2, 1'b0, 32'd0);
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd3);
    in_valid = 1'b1;
    tick(); tick();
    chk("bp_held_in_ready", 32'(in_ready), 32'd0);
    chk("bp_head_stable", out_instr, 32'h0010_0093);
    out_ready = 1'b1;
    c_acc = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bit acc;
      acc = in_valid && in_ready;
      if (out_valid) got.push_back(out_instr);
      tick();
      if (acc) begin in_valid = 1'b0; c_acc = 1'b1; end
    end
    chk("bp_third_accepted", 32'(c_acc), 32'd1);
    chk("bp_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("bp_order0", got[0], 32'h0010_0093);
      chk("bp_order1", got[1], 32'h0020_0093);
      chk("bp_order2", got[2], 32'h0030_0093);
    end

    // randomized traffic checked by the monitor against the model
    for (int k = 0; k < 1500; k++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 4))
        0: imm = 32'($signed($urandom_range(0, 32)) - 16);
        1: imm = 32'(bnd[$urandom_range(0, 17)]);
        2: imm = $urandom;
        3: imm = $urandom & 32'hFFFF_F000;
        default: imm = 32'($signed($urandom_range(0, 32'h20_0000)) - 32'h10_0000) & ~32'd1;
      endcase
      drive(3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1) ? 7'h13 : 7'($urandom),
            5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
      if ($urandom_range(0, 2) == 0) in_imm = {20'd0, 7'($urandom_range(0, 1) * 32), 5'($urandom)};
      in_valid      = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      addr_load     = ($urandom_range(0, 31) == 0);
      addr_load_val = $urandom;
      tick();
    end
    in_valid = 1'b0; addr_load = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("rand_drained", 32'(mq.size()), 32'd0);

    // asynchronous reset with two buffered words, one erroring
    out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2048, 1'b0, 32'd0);
    send(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd1, 1'b0, 32'd0);
    chk("pre_rst_err_cnt_nonzero", 32'(err_cnt != 0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    chk("arst_out_addr", out_addr, 32'd0);
    chk("arst_out_instr", out_instr, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd5, 1'b0, 32'd0);
    chk("arst_first_addr", out_addr, 32'd0);
    chk("arst_first_instr", out_instr, 32'h0050_0093);
    repeat (3) tick();

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's immediate generator: packs operand fields and a 32-bit signed immediate into a RV32I instruction word, per format (R/I/S/B/U/J).
- Used by the on-chip program loader and self-test to build instruction memory images.
- Streaming block: valid/ready input, 2-entry output buffer, byte-address counter per instruction, immediate range/alignment checking with error count.

Parameters:
ADDR_W, 32, width of the output byte address and address counter
ERRCNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input field set valid
in_ready  out  1  encoder can accept this cycle
in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
in_opcode  in  7  opcode field, copied to IR[6:0]
in_rd  in  5  destination register
in_rs1  in  5  source 1
in_rs2  in  5  source 2
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (R only)
in_imm  in  32  signed immediate, byte offset for B/J, full value for U
addr_load  in  1  load address counter
addr_load_val  in  ADDR_W  value loaded
out_valid  out  1  encoded word valid
out_ready  in  1  consumer accepts
out_instr  out  32  encoded instruction
out_addr  out  ADDR_W  byte address assigned to out_instr
out_err  out  1  immediate illegal for format (travels with word)
err_cnt  out  ERRCNT_W  saturating count of accepted words with err

Behaviour:
- Reset (async, rst_n=0): buffer empty, out_valid=0, out_instr=0, out_addr=0, out_err=0, addr counter=0, err_cnt=0, in_ready=1 after release.
- Accept when in_valid && in_ready. in_ready = (buffer occupancy < 2); registered from occupancy, no combinational path from out_ready.
- Latency: word accepted cycle N is on out_* at N+1 if buffer was empty. Strict FIFO order. Pop on out_valid && out_ready. Simultaneous push and pop at occupancy 1: occupancy stays 1, popped word leaves, new word becomes head next cycle.
- out_* stable while out_valid && !out_ready.
- Packing (fields at standard RV32I positions; imm bits listed MSB-first into IR):
  - R: funct7|rs2|rs1|funct3|rd|opcode; in_imm ignored, never errors.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
  - Illegal fmt: instr = 0x00000013 (NOP), err=1.
- Error rules (word still emitted, packed from truncated bits, out_err=1):
  - I/S: imm outside [-2048, 2047].
  - B: imm outside [-4096, 4094] or imm[0]=1.
  - J: imm outside [-1048576, 1048574] or imm[0]=1.
  - U: imm[11:0] != 0.
- Address counter: each accepted word gets the current counter; counter += 4, wraps mod 2^ADDR_W.
- addr_load has priority over increment. If addr_load and an accept coincide, the word gets addr_load_val and the counter becomes addr_load_val+4. addr_load alone sets the counter to addr_load_val. Buffered words keep their original addresses.
- err_cnt increments at accept of an erroring word; saturates at all-ones.
- Reset mid-stream discards buffer contents. No partial word is ever presented.

Optional Feature:
SHAMT_CHECK_EN:
- Defined: I-format with opcode 0010011 and funct3 001 or 101 also errors unless imm[11:5] is 0000000 (funct3 001 or 101) or 0100000 (funct3 101 only). imm[4:0] is the shamt.
- Undefined: shifts are checked only by the plain I-format range rule.

Test Plan:
- fmt=I, opcode 0x13, rd=1, rs1=0, f3=0, imm=5 -> out_instr=0x00500093, out_err=0, out_addr=0, one cycle after accept.
- fmt=S, opcode 0x23, rs1=1, rs2=2, f3=2, imm=8, then fmt=B, opcode 0x63, rs1=rs2=0, imm=-4 -> 0x0020A423 @ addr 0, 0xFE000EE3 @ addr 4.
- addr_load=1, val=0x800 with accept of fmt=J, opcode 0x6F, rd=1, imm=0x800 -> out_instr=0x001000EF, out_addr=0x800; next accepted word gets out_addr=0x804.
- fmt=I, imm=2048 -> out_err=1, out_instr=0x80000093, err_cnt=1. fmt=B, imm=6 (legal) -> out_err=0. fmt=B, imm=3 -> out_err=1, err_cnt=2.
- out_ready=0, three back-to-back in_valid -> first two accepted, in_ready=0 after second, third held. Raise out_ready -> words emerge in order, third accepted once occupancy <2.
- Assert rst_n low with 2 buffered words -> out_valid=0, addr counter=0, err_cnt=0 immediately (async). With SHAMT_CHECK_EN: funct3=5, imm=0x405 -> out_err=0; imm=0x205 -> out_err=1.
